// File: rtl/resp_mon_pkg.sv
// Shared types and helpers for the response-window monitor.
package resp_mon_pkg;

    typedef struct packed {
        logic pass;
        logic fail;
        logic pend;
    } lane_status_t;

    // Width needed to hold an attempt age in 0..h (at least one bit).
    function automatic int unsigned bound_w(input int unsigned h);
        return (h < 1) ? 1 : $clog2(h + 1);
    endfunction

endpackage

// File: rtl/resp_window_lane.sv
// One channel of "req |-> ##[L:H] ack": age shift register, resolution logic
// and a saturating fail counter.
module resp_window_lane
    import resp_mon_pkg::*;
#(
    parameter int unsigned L     = 1,
    parameter int unsigned H     = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             dis_i,
    input  logic             req_i,
    input  logic             ack_i,
    output lane_status_t     status_o,
    output logic             fail_evt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    localparam int unsigned PW = (H > 0) ? H : 1;
    localparam int unsigned AW = bound_w(H);

    logic [PW-1:0] pend_q;
    logic [H:0]    cur;
    logic [H:0]    nxt;
    logic          sat;
    logic          exp_hit;

    always_comb begin
        cur    = '0;
        cur[0] = req_i;
        for (int unsigned k = 1; k <= H; k++) begin
            cur[k] = pend_q[k-1];
        end

        sat = 1'b0;
        for (int unsigned k = 0; k <= H; k++) begin
            if (AW'(k) >= AW'(L)) sat = sat | cur[k];
        end
        sat     = sat & ack_i & ~dis_i;
        exp_hit = cur[H] & ~ack_i & ~dis_i;

        // nxt[H] stays 0: the oldest attempt is always retired this cycle.
        nxt = '0;
        for (int unsigned k = 0; k < H; k++) begin
            nxt[k] = cur[k] & ~(ack_i & (AW'(k) >= AW'(L))) & ~dis_i;
        end
    end

    assign fail_evt_o = exp_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= '0;
            status_o   <= '0;
            fail_cnt_o <= '0;
        end else begin
            pend_q        <= nxt[PW-1:0];
            status_o.pass <= sat;
            status_o.fail <= exp_hit;
            status_o.pend <= |nxt;
            if (clr_i) begin
                fail_cnt_o <= '0;
            end else if (exp_hit && (fail_cnt_o != '1)) begin
                fail_cnt_o <= fail_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/resp_window_monitor.sv
// Multi-channel checker for "req |-> ##[MIN:MAX] ack disable iff (dis)",
// one lane per channel plus a sticky fail flag across all lanes.
module resp_window_monitor
    import resp_mon_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned MIN_DLY    = 1,
    parameter int unsigned MAX_DLY    = 3,
    parameter int unsigned NONOVERLAP = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic [N_CH-1:0]       dis_i,
    input  logic [N_CH-1:0]       req_i,
    input  logic [N_CH-1:0]       ack_i,
    output logic [N_CH-1:0]       pass_o,
    output logic [N_CH-1:0]       fail_o,
    output logic [N_CH-1:0]       pend_o,
    output logic                  fail_any_o,
    output logic [N_CH*CNT_W-1:0] fail_cnt_o
);

    localparam int unsigned L = MIN_DLY + NONOVERLAP;
    localparam int unsigned H = MAX_DLY + NONOVERLAP;

    if (MAX_DLY < MIN_DLY) begin : g_bad_bounds
        $error("resp_window_monitor: MAX_DLY must be >= MIN_DLY");
    end

    lane_status_t    lane_st [N_CH];
    logic [N_CH-1:0] fail_evt;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        resp_window_lane #(
            .L     (L),
            .H     (H),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .clr_i      (clr_i),
            .dis_i      (dis_i[c]),
            .req_i      (req_i[c]),
            .ack_i      (ack_i[c]),
            .status_o   (lane_st[c]),
            .fail_evt_o (fail_evt[c]),
            .fail_cnt_o (fail_cnt_o[c*CNT_W +: CNT_W])
        );

        assign pass_o[c] = lane_st[c].pass;
        assign fail_o[c] = lane_st[c].fail;
        assign pend_o[c] = lane_st[c].pend;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_any_o <= 1'b0;
        end else if (clr_i) begin
            fail_any_o <= 1'b0;
        end else if (|fail_evt) begin
            fail_any_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_resp_window_monitor.sv
// Directed bench for resp_window_monitor with an attempt-list reference model.
module tb_resp_window_monitor;

    localparam int NC   = 2;
    localparam int LO   = 1;
    localparam int HI   = 3;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clr_i;
    logic [NC-1:0] dis_i, req_i, ack_i;
    logic [NC-1:0] pass_o, fail_o, pend_o;
    logic          fail_any_o;
    logic [NC*CW-1:0] fail_cnt_o;

    always #5 clk = ~clk;

    resp_window_monitor #(
        .N_CH       (NC),
        .MIN_DLY    (LO),
        .MAX_DLY    (HI),
        .NONOVERLAP (0),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (clr_i),
        .dis_i      (dis_i),
        .req_i      (req_i),
        .ack_i      (ack_i),
        .pass_o     (pass_o),
        .fail_o     (fail_o),
        .pend_o     (pend_o),
        .fail_any_o (fail_any_o),
        .fail_cnt_o (fail_cnt_o)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: every open attempt is a (channel, start cycle) record.
    typedef struct {
        int ch;
        int start;
    } att_t;

    att_t      att[$];
    att_t      keep[$];
    int        now = 0;
    logic [NC-1:0] m_pass = '0, m_fail = '0, m_pend = '0;
    logic      m_any = 1'b0;
    int        m_cnt[NC];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            att.delete();
            m_pass = '0;
            m_fail = '0;
            m_pend = '0;
            m_any  = 1'b0;
            for (int c = 0; c < NC; c++) m_cnt[c] = 0;
        end else begin
            logic [NC-1:0] s, e;
            s = '0;
            e = '0;
            keep.delete();
            for (int c = 0; c < NC; c++)
                if (req_i[c] && !dis_i[c]) att.push_back('{c, now});
            foreach (att[i]) begin
                int age, c;
                age = now - att[i].start;
                c   = att[i].ch;
                if (dis_i[c]) begin
                end else if (ack_i[c] && age >= LO && age <= HI) begin
                    s[c] = 1'b1;
                end else if (age >= HI) begin
                    e[c] = 1'b1;
                end else begin
                    keep.push_back(att[i]);
                end
            end
            att    = keep;
            m_pend = '0;
            foreach (keep[i]) m_pend[keep[i].ch] = 1'b1;
            m_pass = s;
            m_fail = e;
            for (int c = 0; c < NC; c++) begin
                if (clr_i) m_cnt[c] = 0;
                else if (e[c] && m_cnt[c] < CMAX) m_cnt[c]++;
            end
            if (clr_i) m_any = 1'b0;
            else if (|e) m_any = 1'b1;
            now++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NC*CW-1:0] want_cnt;
            for (int c = 0; c < NC; c++) want_cnt[c*CW +: CW] = CW'(m_cnt[c]);
            check("model_pass", pass_o, m_pass);
            check("model_fail", fail_o, m_fail);
            check("model_pend", pend_o, m_pend);
            check("model_any", fail_any_o, m_any);
            check("model_cnt", fail_cnt_o, want_cnt);
        end
    end

    task automatic step(input logic [NC-1:0] r, input logic [NC-1:0] a,
                        input logic [NC-1:0] d, input logic c);
        @(negedge clk);
        req_i = r;
        ack_i = a;
        dis_i = d;
        clr_i = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        clr_i   = 1'b0;
        dis_i   = '0;
        req_i   = '0;
        ack_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pass", pass_o, 0);
        check("rst_fail", fail_o, 0);
        check("rst_pend", pend_o, 0);
        check("rst_any", fail_any_o, 0);
        check("rst_cnt", fail_cnt_o, 0);
        cmp_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // Ack at age 2 passes.
        step(2'b01, 2'b00, 2'b00, 1'b0);
        idle(1);
        step(2'b00, 2'b01, 2'b00, 1'b0);
        check("s1_pass", pass_o, 2'b01);
        check("s1_fail", fail_o, 2'b00);
        check("s1_pend", pend_o, 2'b00);
        idle(1);
        check("s1_pass_clear", pass_o, 2'b00);
        idle(2);

        // Unanswered request expires at age H.
        step(2'b01, 2'b00, 2'b00, 1'b0);
        idle(2);
        check("s2_pend_open", pend_o, 2'b01);
        idle(1);
        check("s2_fail", fail_o, 2'b01);
        check("s2_cnt", fail_cnt_o, 4'b0001);
        check("s2_any", fail_any_o, 1);
        idle(2);

        // Disable on ch1 drops its attempt; ch0 passes undisturbed.
        step(2'b11, 2'b00, 2'b00, 1'b0);
        idle(1);
        step(2'b00, 2'b01, 2'b10, 1'b0);
        check("s3_pass", pass_o, 2'b01);
        check("s3_pend", pend_o, 2'b00);
        idle(2);
        check("s3_nofail", fail_o, 2'b00);
        idle(2);

        // Age-0 ack does not count; later ack retires both attempts at once.
        step(2'b01, 2'b01, 2'b00, 1'b0);
        check("s4_early_ack", pass_o, 2'b00);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b01, 2'b00, 1'b0);
        check("s4_pass", pass_o, 2'b01);
        check("s4_pend", pend_o, 2'b00);
        idle(1);
        check("s4_single", pass_o, 2'b00);
        idle(2);
        check("s4_nofail", fail_o, 2'b00);
        idle(1);

        // Pass for first attempt, later one expires.
        step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b01, 2'b00, 1'b0);
        check("s5_pass", pass_o, 2'b01);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        idle(3);
        check("s5_fail", fail_o, 2'b01);
        check("s5_cnt", fail_cnt_o, 4'b0010);
        idle(2);

        // Counter saturation at 3.
        step(2'b00, 2'b00, 2'b00, 1'b1);
        check("s6_clr_cnt", fail_cnt_o, 0);
        check("s6_clr_any", fail_any_o, 0);
        for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 2'b00, 1'b0);
        check("s6_cnt_mid", fail_cnt_o, 4'b0010);
        idle(3);
        check("s6_cnt_sat", fail_cnt_o, 4'b0011);
        check("s6_fail", fail_o, 2'b01);
        idle(1);

        // Clear wins over a simultaneous expiry; fail pulse still shows.
        step(2'b01, 2'b00, 2'b00, 1'b0);
        idle(2);
        step(2'b00, 2'b00, 2'b00, 1'b1);
        check("s6_clr_fail", fail_o, 2'b01);
        check("s6_clr_cnt2", fail_cnt_o, 0);
        check("s6_clr_any2", fail_any_o, 0);
        idle(1);

        // Async reset while an attempt is open.
        step(2'b01, 2'b00, 2'b00, 1'b0);
        idle(3);
        check("s7_cnt", fail_cnt_o, 4'b0001);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        idle(1);
        check("s7_pend", pend_o, 2'b01);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("s7_rst_pend", pend_o, 0);
        check("s7_rst_cnt", fail_cnt_o, 0);
        check("s7_rst_any", fail_any_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("s7_no_fail", fail_o, 0);
        end

        // Ack-delay sweep on ch1 across and beyond the window.
        for (int d = 0; d <= 4; d++) begin
            step(2'b10, (d == 0) ? 2'b10 : 2'b00, 2'b00, 1'b0);
            for (int k = 1; k <= 4; k++)
                step(2'b00, (k == d) ? 2'b10 : 2'b00, 2'b00, 1'b0);
            idle(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/resp_window_monitor.md
Name: resp_window_monitor

Overview:
Multi-channel synthesizable checker for the property class "req |-> ##[MIN:MAX] ack" with "disable iff (dis)". It is the parametrised successor to hand-written per-signal SVA checks. Per channel it tracks every overlapping attempt exactly, and reports registered pass (cover) and fail pulses plus saturating fail counts. It sits beside the DUT in formal and simulation harnesses and drives sticky error status.

Parameters:
N_CH, 4, number of independent channels
MIN_DLY, 1, lower window bound in cycles (0 allowed)
MAX_DLY, 3, upper window bound; must satisfy MAX_DLY >= MIN_DLY (elaboration error otherwise)
NONOVERLAP, 0, 1 = "|=>" semantics: effective bounds become MIN_DLY+1 and MAX_DLY+1
CNT_W, 8, width of each fail counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear of fail counters and fail_any_o
dis_i  in  N_CH  per-channel disable condition, sampled each cycle
req_i  in  N_CH  antecedent per channel
ack_i  in  N_CH  consequent per channel
pass_o  out  N_CH  one-cycle pulse: at least one attempt satisfied in the previous cycle
fail_o  out  N_CH  one-cycle pulse: at least one attempt expired unsatisfied in the previous cycle
pend_o  out  N_CH  at least one attempt outstanding (registered)
fail_any_o  out  1  sticky OR of all fail events
fail_cnt_o  out  N_CH*CNT_W  per-channel saturating fail count; channel c at bits [c*CNT_W +: CNT_W]

Behaviour:
- Reset (reset_n low, async): all attempt state cleared; every output is 0.
- Let L = MIN_DLY+NONOVERLAP and H = MAX_DLY+NONOVERLAP.
- Per channel, register pend_q[H-1:0]; bit k = attempt started k+1 cycles ago, still open. No storage when H = 0.
- In cycle t, form the combinational age vector: cur[0] = req_i, cur[k] = pend_q[k-1] for k = 1..H.
- Satisfaction: sat = ack_i & OR(cur[L..H]). An ack consumes all open attempts whose age is in [L,H]. Younger attempts stay open.
- Expiry: exp = cur[H] & ~ack_i. The attempt at age H is always retired.
- Next state: pend_q[k] <= cur[k] & ~(ack_i & k >= L) for k < H.
- Disable: if dis_i[c] is high in cycle t, channel c clears all attempts, including any req at t. sat and exp are forced to 0 for that cycle.
- Outputs (latency 1): pass_o <= sat; fail_o <= exp; pend_o <= OR(next pend_q).
- pass_o and fail_o may assert together when different attempts resolve in the same cycle.
- req and ack in the same cycle with L = 0: that attempt passes immediately.
- Counter: fail_cnt increments on exp and saturates at 2^CNT_W-1 (no wrap).
- fail_any_o sets on any exp.
- clr_i has priority: fail_cnt <= 0 and fail_any_o <= 0, even if exp occurs in the same cycle. pass_o and fail_o are unaffected by clr_i.
- reset_n asserted mid-attempt: attempts are lost, no fail is reported. On release, tracking resumes on the next edge.

Decomposition:
- Package resp_mon_pkg holds the lane_status_t struct {pass, fail, pend} and a function for the clog2 width of the bounds.
- Sub-module resp_window_lane holds one channel's pend_q, sat/exp logic and fail counter. The top generates N_CH instances and ORs the fail_any source.

Test Plan:
- N_CH=2, L=1, H=3. req_i[0] at cyc 10, ack_i[0] at 12 -> pass_o[0]=1 at 13; no fail_o; pend_o[0]=0 from 13.
- req_i[0] at 10, no ack -> fail_o[0]=1 at 14; fail_cnt ch0=1; fail_any_o=1 from 14.
- req_i[1] at 10, dis_i[1] at 12 -> no pass/fail on ch1; pend_o[1]=0 at 13; ch0 unaffected.
- req_i[0] at 10 and 11, ack at 10 (age 0 < L, no pass), ack at 12 -> single pass_o pulse at 13; both attempts retired.
- req_i[0] at 10 and 12, ack at 11 -> pass at 12; attempt from 12 expires at 15 -> fail_o at 16, same-cycle pass/fail case covered separately.
- CNT_W=2, five expiries -> count 3 (saturated); clr_i with simultaneous expiry -> 0. reset_n low with pend_o=1 -> all outputs 0 asynchronously, no fail afterward.
